// File: rtl/bcd_counter_n.sv
// bcd_counter_n: N-digit BCD up/down counter with tick divider, load, limit, wrap pulse and 7-segment outputs.
module bcd_counter_n #(
    parameter int DIGITS = 2,
    parameter int DIV = 50000000,
    parameter logic [4*DIGITS-1:0] LIMIT = 8'h99
) (
    input  logic                  CLOCK_50,
    input  logic                  RS,
    input  logic                  EN,
    input  logic                  UP,
    input  logic                  LOAD,
    input  logic [4*DIGITS-1:0]   LOAD_VAL,
    input  logic                  BLANK_LZ,
    output logic [4*DIGITS-1:0]   BCD,
    output logic [7*DIGITS-1:0]   HEX,
    output logic                  TICK,
    output logic                  TC
);
    localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DMAX = DW'(DIV - 1);
    localparam int W = 4 * DIGITS;

    logic [DW-1:0] div;
    logic          wrap;
    logic [W-1:0]  inc, dec, san, load_v;
    logic          c, b, z;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: seg7 = 7'b1000000;
            4'd1: seg7 = 7'b1111001;
            4'd2: seg7 = 7'b0100100;
            4'd3: seg7 = 7'b0110000;
            4'd4: seg7 = 7'b0011001;
            4'd5: seg7 = 7'b0010010;
            4'd6: seg7 = 7'b0000010;
            4'd7: seg7 = 7'b1111000;
            4'd8: seg7 = 7'b0000000;
            4'd9: seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    assign wrap = div == DMAX;

    // Ripple decimal carry/borrow; sanitised load value clamped to the limit.
    always_comb begin
        inc = BCD;
        dec = BCD;
        san = '0;
        c = 1'b1;
        b = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            inc[4*k+:4] = c ? (BCD[4*k+:4] == 4'd9 ? 4'd0 : BCD[4*k+:4] + 4'd1) : BCD[4*k+:4];
            c = c && BCD[4*k+:4] == 4'd9;
            dec[4*k+:4] = b ? (BCD[4*k+:4] == 4'd0 ? 4'd9 : BCD[4*k+:4] - 4'd1) : BCD[4*k+:4];
            b = b && BCD[4*k+:4] == 4'd0;
            san[4*k+:4] = LOAD_VAL[4*k+:4] > 4'd9 ? 4'd0 : LOAD_VAL[4*k+:4];
        end
        load_v = san > LIMIT ? LIMIT : san;
    end

    always_ff @(posedge CLOCK_50 or posedge RS) begin
        if (RS) begin
            div  <= '0;
            BCD  <= '0;
            TICK <= 1'b0;
            TC   <= 1'b0;
        end else begin
            TICK <= wrap;
            TC   <= 1'b0;
            div  <= (LOAD || wrap) ? '0 : div + 1'b1;
            if (LOAD)
                BCD <= load_v;
            else if (wrap && EN) begin
                if (UP) begin
                    BCD <= BCD == LIMIT ? '0 : inc;
                    TC  <= BCD == LIMIT;
                end else begin
                    BCD <= BCD == '0 ? LIMIT : dec;
                    TC  <= BCD == '0;
                end
            end
        end
    end

    // z stays high while this digit and every higher one are zero.
    always_comb begin
        HEX = '1;
        z = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            z = z && BCD[4*k+:4] == 4'd0;
            HEX[7*k+:7] = (BLANK_LZ && k > 0 && z) ? 7'b1111111 : seg7(BCD[4*k+:4]);
        end
    end
endmodule

// File: tb/tb_bcd_counter_n.sv
// tb_bcd_counter_n: four counter configurations on shared random stimulus against a decimal-arithmetic model.
module tb_bcd_counter_n;
    logic CLOCK_50 = 1'b0;
    logic RS = 1'b1;
    logic EN = 1'b0, UP = 1'b1, LOAD = 1'b0, BLANK_LZ = 1'b0;
    logic [11:0] LOAD_VAL = '0;

    logic [7:0]  bcd_a, bcd_b;
    logic [11:0] bcd_c;
    logic [3:0]  bcd_d;
    logic [13:0] hex_a, hex_b;
    logic [20:0] hex_c;
    logic [6:0]  hex_d;
    logic tick_a, tick_b, tick_c, tick_d, tc_a, tc_b, tc_c, tc_d;

    logic [31:0] bcd_w[4], hex_w[4];
    logic        tick_w[4], tc_w[4];

    int nd[4]  = '{2, 2, 3, 1};
    int dv[4]  = '{4, 4, 3, 1};
    int lim[4] = '{99, 59, 250, 9};
    logic [6:0] seg[10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    int m_cnt[4], m_ph[4];
    logic m_tick[4], m_tc[4];
    int checks = 0, errors = 0;
    bit cmp_en = 1'b0;
    int tc_pulses_a = 0, tick_pulses_a = 0, t0;

    always #5 CLOCK_50 = ~CLOCK_50;

    bcd_counter_n #(.DIGITS(2), .DIV(4), .LIMIT(8'h99)) dut_a (
        .CLOCK_50(CLOCK_50), .RS(RS), .EN(EN), .UP(UP), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL[7:0]),
        .BLANK_LZ(BLANK_LZ), .BCD(bcd_a), .HEX(hex_a), .TICK(tick_a), .TC(tc_a));
    bcd_counter_n #(.DIGITS(2), .DIV(4), .LIMIT(8'h59)) dut_b (
        .CLOCK_50(CLOCK_50), .RS(RS), .EN(EN), .UP(UP), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL[7:0]),
        .BLANK_LZ(BLANK_LZ), .BCD(bcd_b), .HEX(hex_b), .TICK(tick_b), .TC(tc_b));
    bcd_counter_n #(.DIGITS(3), .DIV(3), .LIMIT(12'h250)) dut_c (
        .CLOCK_50(CLOCK_50), .RS(RS), .EN(EN), .UP(UP), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL),
        .BLANK_LZ(BLANK_LZ), .BCD(bcd_c), .HEX(hex_c), .TICK(tick_c), .TC(tc_c));
    bcd_counter_n #(.DIGITS(1), .DIV(1), .LIMIT(4'h9)) dut_d (
        .CLOCK_50(CLOCK_50), .RS(RS), .EN(EN), .UP(UP), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL[3:0]),
        .BLANK_LZ(BLANK_LZ), .BCD(bcd_d), .HEX(hex_d), .TICK(tick_d), .TC(tc_d));

    assign bcd_w[0] = {24'b0, bcd_a};
    assign bcd_w[1] = {24'b0, bcd_b};
    assign bcd_w[2] = {20'b0, bcd_c};
    assign bcd_w[3] = {28'b0, bcd_d};
    assign hex_w[0] = {18'b0, hex_a};
    assign hex_w[1] = {18'b0, hex_b};
    assign hex_w[2] = {11'b0, hex_c};
    assign hex_w[3] = {25'b0, hex_d};
    assign tick_w[0] = tick_a;
    assign tick_w[1] = tick_b;
    assign tick_w[2] = tick_c;
    assign tick_w[3] = tick_d;
    assign tc_w[0] = tc_a;
    assign tc_w[1] = tc_b;
    assign tc_w[2] = tc_c;
    assign tc_w[3] = tc_d;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int load_dec(input int i);
        int v = 0, p = 1, n;
        for (int k = 0; k < nd[i]; k++) begin
            n = int'((LOAD_VAL >> (4 * k)) & 12'hF);
            v += (n > 9 ? 0 : n) * p;
            p *= 10;
        end
        return v > lim[i] ? lim[i] : v;
    endfunction

    function automatic int next_cnt(input int i);
        if (LOAD) return load_dec(i);
        if (!(m_ph[i] == dv[i] - 1 && EN)) return m_cnt[i];
        return UP ? (m_cnt[i] + 1) % (lim[i] + 1) : (m_cnt[i] + lim[i]) % (lim[i] + 1);
    endfunction

    function automatic logic [31:0] to_bcd(input int v, input int n);
        logic [31:0] r = '0;
        for (int k = 0; k < n; k++) begin
            r[4*k+:4] = 4'(v % 10);
            v /= 10;
        end
        return r;
    endfunction

    function automatic logic [31:0] exp_hex(input int v, input int n, input logic blank);
        logic [31:0] h = '0;
        int p = 1;
        for (int k = 0; k < n; k++) begin
            h[7*k+:7] = (blank && k > 0 && v < p) ? 7'b1111111 : seg[(v / p) % 10];
            p *= 10;
        end
        return h;
    endfunction

    always @(posedge CLOCK_50 or posedge RS) begin
        for (int i = 0; i < 4; i++) begin
            if (RS) begin
                m_cnt[i] <= 0;
                m_ph[i] <= 0;
                m_tick[i] <= 1'b0;
                m_tc[i] <= 1'b0;
            end else begin
                m_tick[i] <= m_ph[i] == dv[i] - 1;
                m_ph[i] <= (LOAD || m_ph[i] == dv[i] - 1) ? 0 : m_ph[i] + 1;
                m_cnt[i] <= next_cnt(i);
                m_tc[i] <= !LOAD && m_ph[i] == dv[i] - 1 && EN && (UP ? m_cnt[i] == lim[i] : m_cnt[i] == 0);
            end
        end
    end

    always @(negedge CLOCK_50) begin
        if (cmp_en) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("bcd%0d", i), bcd_w[i], to_bcd(m_cnt[i], nd[i]));
                chk($sformatf("hex%0d", i), hex_w[i], exp_hex(m_cnt[i], nd[i], BLANK_LZ));
                chk($sformatf("tick%0d", i), 32'(tick_w[i]), 32'(m_tick[i]));
                chk($sformatf("tc%0d", i), 32'(tc_w[i]), 32'(m_tc[i]));
            end
        end
    end

    always @(negedge CLOCK_50 or posedge RS) begin
        if (RS) tc_pulses_a <= 0;
        else if (tc_a) tc_pulses_a <= tc_pulses_a + 1;
        if (!RS && tick_a) tick_pulses_a <= tick_pulses_a + 1;
    end

    task automatic step(input int n);
        repeat (n) @(posedge CLOCK_50);
        #2;
    endtask

    task automatic load(input logic [11:0] v);
        LOAD_VAL = v;
        LOAD = 1'b1;
        step(1);
        LOAD = 1'b0;
    endtask

    initial begin
        step(2);
        cmp_en = 1'b1;
        chk("reset_bcd_a", 32'(bcd_a), 32'h0);
        chk("reset_hex_a", 32'(hex_a), 32'({7'b1000000, 7'b1000000}));
        BLANK_LZ = 1'b1;
        #1;
        chk("reset_hex_c_blank", 32'(hex_c), 32'({7'b1111111, 7'b1111111, 7'b1000000}));
        BLANK_LZ = 1'b0;
        EN = 1'b1;
        UP = 1'b1;
        RS = 1'b0;
        step(40);
        chk("up_09_to_10", 32'(bcd_a), 32'h10);
        chk("hex_10", 32'(hex_a), 32'({7'b1111001, 7'b1000000}));
        step(360);
        chk("wrap_99_00", 32'(bcd_a), 32'h00);
        chk("wrap_tc", 32'(tc_a), 32'h1);
        chk("limit59_after100", 32'(bcd_b), 32'h40);
        UP = 1'b0;
        step(1);
        chk("tc_one_cycle", 32'(tc_a), 32'h0);
        chk("tc_pulse_count", 32'(tc_pulses_a), 32'h1);
        step(3);
        chk("down_00_99", 32'(bcd_a), 32'h99);
        chk("down_tc", 32'(tc_a), 32'h1);
        step(4);
        chk("down_98", 32'(bcd_a), 32'h98);
        chk("down_98_tc", 32'(tc_a), 32'h0);
        step(3);
        UP = 1'b1;
        load(12'h057);
        chk("load_57", 32'(bcd_a), 32'h57);
        chk("load_tc", 32'(tc_a), 32'h0);
        step(3);
        chk("load_hold", 32'(bcd_a), 32'h57);
        step(1);
        chk("load_then_58", 32'(bcd_a), 32'h58);
        load(12'h0A3);
        chk("load_sanitise", 32'(bcd_a), 32'h03);
        load(12'h075);
        chk("load_clamp_b", 32'(bcd_b), 32'h59);
        chk("load_75_a", 32'(bcd_a), 32'h75);
        step(4);
        chk("b_up_wrap", 32'(bcd_b), 32'h00);
        chk("b_up_tc", 32'(tc_b), 32'h1);
        UP = 1'b0;
        step(4);
        chk("b_down_wrap", 32'(bcd_b), 32'h59);
        chk("b_down_tc", 32'(tc_b), 32'h1);
        load(12'h010);
        step(4);
        chk("borrow_10_09", 32'(bcd_a), 32'h09);
        EN = 1'b0;
        t0 = tick_pulses_a;
        step(20);
        chk("en0_hold", 32'(bcd_a), 32'h09);
        chk("en0_ticks", 32'(tick_pulses_a - t0), 32'd5);
        BLANK_LZ = 1'b1;
        load(12'h007);
        chk("blank_007", 32'(hex_c), 32'({7'b1111111, 7'b1111111, 7'b1111000}));
        load(12'h070);
        chk("blank_070", 32'(hex_c), 32'({7'b1111111, 7'b1111000, 7'b1000000}));
        BLANK_LZ = 1'b0;
        #1;
        chk("noblank_070", 32'(hex_c), 32'({7'b1000000, 7'b1111000, 7'b1000000}));
        repeat (3000) begin
            step(1);
            EN = $urandom_range(0, 3) != 0;
            UP = 1'($urandom_range(0, 1));
            LOAD = $urandom_range(0, 15) == 0;
            LOAD_VAL = 12'($urandom_range(0, 4095));
            BLANK_LZ = 1'($urandom_range(0, 1));
        end
        step(1);
        EN = 1'b1;
        UP = 1'b1;
        load(12'h041);
        step(4);
        chk("pre_reset_42", 32'(bcd_a), 32'h42);
        chk("pre_reset_tick", 32'(tick_a), 32'h1);
        #1 RS = 1'b1;
        #1;
        chk("async_bcd", 32'(bcd_a), 32'h0);
        chk("async_tick", 32'(tick_a), 32'h0);
        chk("async_tc", 32'(tc_b), 32'h0);
        step(2);
        RS = 1'b0;
        step(1);
        chk("rel_tick_a1", 32'(tick_a), 32'h0);
        chk("div1_tick", 32'(tick_d), 32'h1);
        chk("div1_count", 32'(bcd_d), 32'h1);
        step(2);
        chk("rel_tick_a3", 32'(tick_a), 32'h0);
        step(1);
        chk("rel_tick_a4", 32'(tick_a), 32'h1);
        chk("rel_count", 32'(bcd_a), 32'h01);
        step(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
